// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: register choice encoding, mul/div FSM states,
// default unit latencies and the canned choice patterns used by the hazard unit.
package pipe_ctrl_pkg;

    localparam int unsigned CH_W     = 2;
    localparam int unsigned REG_W    = 5;

    localparam logic [CH_W-1:0] CH_FLUSH = 2'b00;
    localparam logic [CH_W-1:0] CH_LOAD  = 2'b01;
    localparam logic [CH_W-1:0] CH_HOLD  = 2'b10;

    localparam int unsigned MUL_CYCLES_DEFAULT = 4;
    localparam int unsigned DIV_CYCLES_DEFAULT = 32;
    localparam int unsigned CNT_W_DEFAULT      = 6;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [CH_W-1:0] pc;
        logic [CH_W-1:0] if_id;
        logic [CH_W-1:0] id_ex;
        logic [CH_W-1:0] ex_mem;
        logic [CH_W-1:0] mem_wb;
    } pipe_choice_t;

    function automatic pipe_choice_t choice_run();
        pipe_choice_t c;
        c.pc     = CH_LOAD;
        c.if_id  = CH_LOAD;
        c.id_ex  = CH_LOAD;
        c.ex_mem = CH_LOAD;
        c.mem_wb = CH_LOAD;
        return c;
    endfunction

    // Freeze PC and IF/ID, inject a bubble into ID/EX, let older stages drain.
    function automatic pipe_choice_t choice_stall();
        pipe_choice_t c;
        c.pc     = CH_HOLD;
        c.if_id  = CH_HOLD;
        c.id_ex  = CH_FLUSH;
        c.ex_mem = CH_LOAD;
        c.mem_wb = CH_LOAD;
        return c;
    endfunction

    // PC still loads: the exception vector is selected outside this block.
    function automatic pipe_choice_t choice_exc();
        pipe_choice_t c;
        c.pc     = CH_LOAD;
        c.if_id  = CH_FLUSH;
        c.id_ex  = CH_FLUSH;
        c.ex_mem = CH_FLUSH;
        c.mem_wb = CH_FLUSH;
        return c;
    endfunction

endpackage : pipe_ctrl_pkg

// File: rtl/md_busy_counter.sv
// Tracks EX occupancy of the multi-cycle mul/div unit: RUN/MD_BUSY FSM,
// countdown of remaining cycles and a one-cycle completion pulse.
module md_busy_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start_i,
    input  logic md_is_div_i,
    input  logic abort_i,
    output logic md_busy_o,
    output logic md_done_o
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_e        fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_done_q, md_done_d;

    // Next-state: a start is only accepted from RUN; exceptions cancel silently.
    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        md_done_d = 1'b0;
        unique case (fsm_q)
            ST_RUN: begin
                if (md_start_i && !abort_i) begin
                    fsm_d = ST_MD_BUSY;
                    cnt_d = md_is_div_i ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_MD_BUSY: begin
                if (abort_i) begin
                    fsm_d = ST_RUN;
                    cnt_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    fsm_d     = ST_RUN;
                    md_done_d = 1'b1;
                end
            end
            default: begin
                fsm_d = ST_RUN;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= ST_RUN;
            cnt_q     <= '0;
            md_done_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            md_done_q <= md_done_d;
        end
    end

    assign md_busy_o = (fsm_q == ST_MD_BUSY);
    assign md_done_o = md_done_q;

endmodule : md_busy_counter

// File: rtl/hazard_choice_ctrl.sv
// Pipeline hazard unit: load-use and HI/LO interlocks plus exception flush,
// producing the choice code of every pipeline register in the same cycle.
module hazard_choice_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_needs_hilo,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_md_start,
    input  logic             ex_md_is_div,
    input  logic             exc_req,
    output logic [CH_W-1:0]  pc_choice,
    output logic [CH_W-1:0]  if_id_choice,
    output logic [CH_W-1:0]  id_ex_choice,
    output logic [CH_W-1:0]  ex_mem_choice,
    output logic [CH_W-1:0]  mem_wb_choice,
    output logic             md_busy,
    output logic             md_done
);

    logic         rs_hit_c;
    logic         rt_hit_c;
    logic         lu_c;
    logic         md_c;
    pipe_choice_t ch_c;

    md_busy_counter #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_counter (
        .clk         (clk),
        .rst_n       (reset),
        .md_start_i  (ex_md_start),
        .md_is_div_i (ex_md_is_div),
        .abort_i     (exc_req),
        .md_busy_o   (md_busy),
        .md_done_o   (md_done)
    );

    // $zero is never a real producer, so a load into r0 creates no hazard.
    assign rs_hit_c = id_uses_rs && (id_rs == ex_rt);
    assign rt_hit_c = id_uses_rt && (id_rt == ex_rt);
    assign lu_c     = ex_mem_read && (ex_rt != REG_W'(0)) && (rs_hit_c || rt_hit_c);

    // Including the start cycle keeps a HI/LO reader from slipping past the unit.
    assign md_c = id_needs_hilo && (md_busy || ex_md_start);

    always_comb begin
        ch_c = choice_run();
        if (!reset) begin
            ch_c = choice_run();
        end else if (exc_req) begin
            ch_c = choice_exc();
        end else if (lu_c || md_c) begin
            ch_c = choice_stall();
        end
    end

    assign pc_choice     = ch_c.pc;
    assign if_id_choice  = ch_c.if_id;
    assign id_ex_choice  = ch_c.id_ex;
    assign ex_mem_choice = ch_c.ex_mem;
    assign mem_wb_choice = ch_c.mem_wb;

endmodule : hazard_choice_ctrl

// File: tb/tb_hazard_choice_ctrl.sv
// Directed bench for hazard_choice_ctrl: stimulus pushes expected per-cycle
// outputs into a queue, an independent monitor pops and compares them.
module tb_hazard_choice_ctrl;

    localparam logic [9:0] EXP_RUN = 10'b01_01_01_01_01;
    localparam logic [9:0] EXP_STL = 10'b10_10_00_01_01;
    localparam logic [9:0] EXP_EXC = 10'b01_00_00_00_00;

    typedef struct packed {
        logic [9:0] ch;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, id_needs_hilo;
    logic       ex_mem_read, ex_md_start, ex_md_is_div, exc_req;
    logic [1:0] pc_choice, if_id_choice, id_ex_choice, ex_mem_choice, mem_wb_choice;
    logic       md_busy, md_done;

    int    checks   = 0;
    int    failures = 0;
    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    hazard_choice_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_needs_hilo (id_needs_hilo),
        .ex_mem_read   (ex_mem_read),
        .ex_rt         (ex_rt),
        .ex_md_start   (ex_md_start),
        .ex_md_is_div  (ex_md_is_div),
        .exc_req       (exc_req),
        .pc_choice     (pc_choice),
        .if_id_choice  (if_id_choice),
        .id_ex_choice  (id_ex_choice),
        .ex_mem_choice (ex_mem_choice),
        .mem_wb_choice (mem_wb_choice),
        .md_busy       (md_busy),
        .md_done       (md_done)
    );

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic hilo,
                          input logic mr, input logic [4:0] xrt,
                          input logic st, input logic dv, input logic ex);
        id_rs         = rs;
        id_rt         = rt;
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        id_needs_hilo = hilo;
        ex_mem_read   = mr;
        ex_rt         = xrt;
        ex_md_start   = st;
        ex_md_is_div  = dv;
        exc_req       = ex;
    endtask

    // Queue the expectation for the current cycle, then advance to the next one.
    task automatic expect_cyc(input logic [9:0] ch, input logic busy,
                              input logic done, input string nm);
        exp_t e;
        e.ch   = ch;
        e.busy = busy;
        e.done = done;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t       e;
        string      nm;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {pc_choice, if_id_choice, id_ex_choice, ex_mem_choice, mem_wb_choice};
                checks++;
                if (act !== e.ch) begin
                    failures++;
                    $display("FAIL %s choices: got %b required %b", nm, act, e.ch);
                end
                checks++;
                if (md_busy !== e.busy) begin
                    failures++;
                    $display("FAIL %s md_busy: got %b required %b", nm, md_busy, e.busy);
                end
                checks++;
                if (md_done !== e.done) begin
                    failures++;
                    $display("FAIL %s md_done: got %b required %b", nm, md_done, e.done);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // In reset: hazards, exceptions and starts are all masked
        set_in(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "rst_mask");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "rst_start");
        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "idle");

        // Load-use on rs, then released
        set_in(5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        expect_cyc(EXP_STL, 1'b0, 1'b0, "lu_rs");
        ex_mem_read = 1'b0;
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "lu_release");
        // Load-use on rt
        set_in(5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        expect_cyc(EXP_STL, 1'b0, 1'b0, "lu_rt");
        // Matching rs that the instruction does not read
        set_in(5'd8, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "lu_unused_rs");
        // Load into $zero
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "lu_zero");
        // Exception beats load-use
        set_in(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        expect_cyc(EXP_EXC, 1'b0, 1'b0, "exc_over_lu");

        // Divide followed by mflo
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        expect_cyc(EXP_STL, 1'b0, 1'b0, "div_start");
        ex_md_start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                set_in(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
                expect_cyc(EXP_STL, 1'b1, 1'b0, "div_and_lu");
                ex_mem_read = 1'b0;
            end else begin
                expect_cyc(EXP_STL, 1'b1, 1'b0, "div_busy");
            end
        end
        expect_cyc(EXP_RUN, 1'b0, 1'b1, "div_done");
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "div_after");
        id_needs_hilo = 1'b0;

        // Multiply with an unrelated ID instruction
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "mul_start");
        ex_md_start = 1'b0;
        for (int k = 1; k <= 4; k++) expect_cyc(EXP_RUN, 1'b1, 1'b0, "mul_busy");
        expect_cyc(EXP_RUN, 1'b0, 1'b1, "mul_done");
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "mul_after");

        // Start coinciding with an exception never begins
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        expect_cyc(EXP_EXC, 1'b0, 1'b0, "exc_start");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "exc_start_after");

        // Exception during divide aborts without md_done
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        expect_cyc(EXP_STL, 1'b0, 1'b0, "abort_start");
        ex_md_start = 1'b0;
        for (int k = 1; k <= 9; k++) expect_cyc(EXP_STL, 1'b1, 1'b0, "abort_busy");
        exc_req = 1'b1;
        expect_cyc(EXP_EXC, 1'b1, 1'b0, "abort_exc");
        exc_req = 1'b0;
        for (int k = 0; k < 25; k++) expect_cyc(EXP_RUN, 1'b0, 1'b0, "abort_after");
        id_needs_hilo = 1'b0;

        // Asynchronous reset in the middle of a divide
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        expect_cyc(EXP_STL, 1'b0, 1'b0, "ar_start");
        ex_md_start = 1'b0;
        for (int k = 1; k <= 3; k++) expect_cyc(EXP_STL, 1'b1, 1'b0, "ar_busy");
        reset = 1'b0;
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "ar_in_reset");
        reset = 1'b1;
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "ar_release");
        id_needs_hilo = 1'b0;
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "ar_run");
        expect_cyc(EXP_RUN, 1'b0, 1'b0, "ar_idle");

        // Let the monitor drain the queue, bounded
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_choice_ctrl

// File: doc/hazard_choice_ctrl.md
Name: hazard_choice_ctrl

Overview:
- Pipeline hazard/control unit that drives the 2-bit `choice` inputs of every pipeline register: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards, tracks a multi-cycle mul/div unit with a countdown FSM, and flushes the pipe on MEM-stage exceptions.
- Branches resolve in ID with a delay slot, so this block never flushes for branches.

Parameters:
- MUL_CYCLES, 4, EX occupancy of mult/multu in cycles (≥1).
- DIV_CYCLES, 32, EX occupancy of div/divu in cycles (≥1).
- CNT_W, 6, countdown counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_needs_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo or mult/div.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rt  in  5  destination register of the EX load.
- ex_md_start  in  1  mult/div in EX this cycle.
- ex_md_is_div  in  1  qualifies ex_md_start; 1 = divide.
- exc_req  in  1  MEM-stage exception or interrupt taken this cycle.
- pc_choice  out  2  choice for PC register.
- if_id_choice  out  2  choice for IF/ID.
- id_ex_choice  out  2  choice for ID/EX.
- ex_mem_choice  out  2  choice for EX/MEM.
- mem_wb_choice  out  2  choice for MEM/WB.
- md_busy  out  1  state == MD_BUSY.
- md_done  out  1  one-cycle pulse: HI/LO final.

Behaviour:
- Choice encoding: 00 FLUSH (clear register), 01 LOAD, 10 HOLD. 11 is never driven.
- All choice outputs are combinational from inputs and state. No added latency.
- FSM states: RUN and MD_BUSY. Registered state: fsm, cnt[CNT_W-1:0], md_done.
- Reset (reset=0, asynchronous): fsm=RUN, cnt=0, md_done=0. Combinational outputs during reset: all choices = 01, md_busy=0.
- RUN→MD_BUSY when ex_md_start && !exc_req. Load cnt = (ex_md_is_div ? DIV_CYCLES : MUL_CYCLES) - 1.
  - If the loaded value is 0, the block goes straight back to RUN next cycle and md_done pulses then.
- In MD_BUSY:
  - cnt != 0: cnt decrements.
  - cnt == 0: next state RUN, md_done=1 for exactly the following cycle.
- exc_req in MD_BUSY: abort. Next state RUN, cnt=0, no md_done.
- ex_md_start while in MD_BUSY is ignored; the stall rule below makes this unreachable.
- Hazard terms:
  - lu = ex_mem_read && ex_rt != 0 && ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt)).
  - md = id_needs_hilo && (fsm == MD_BUSY || ex_md_start). Covering same-cycle start avoids a one-cycle escape.
- Priority, highest first:
  1. exc_req: pc=01 (vector mux is external), if_id=00, id_ex=00, ex_mem=00, mem_wb=00.
  2. lu or md: pc=10, if_id=10, id_ex=00, ex_mem=01, mem_wb=01.
  3. Otherwise: all 01.
- Simultaneous lu and md: a single stall pattern (identical). It persists until both clear.
- Stall releases in the first cycle fsm == RUN. The final MD_BUSY cycle (cnt==0) still stalls.
- Reset deasserted mid-stall: the pipe resumes in RUN with no stall memory.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - CH_FLUSH=2'b00, CH_LOAD=2'b01, CH_HOLD=2'b10.
  - State encoding for RUN and MD_BUSY.
  - Default MUL_CYCLES and DIV_CYCLES, shared with the mul/div unit.
- One sub-module: md_busy_counter, holding the FSM, the countdown and md_done.
- Hazard compare and priority mux stay in the top level.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_uses_rs=1, id_rs=8 → one cycle of pc=10, if_id=10, id_ex=00, ex_mem=01, mem_wb=01. All 01 after ex_mem_read drops.
- $zero load: ex_rt=0, id_rs=0 → all 01, no stall.
- Divide then mflo:
  - Stimulus: ex_md_start=1, ex_md_is_div=1 at cycle T; id_needs_hilo=1 held.
  - Required: stall asserted cycles T..T+32, md_busy=1 T+1..T+32, md_done=1 at T+33, choices all 01 at T+33.
- Multiply with unrelated ID instruction: id_needs_hilo=0 → md_busy=1 for 4 cycles, no stall, md_done one cycle after.
- Exception during divide: exc_req=1 at T+10 → choices 01/00/00/00/00 that cycle. md_busy=0 at T+11, md_done never pulses.
- Async reset mid-divide: reset=0 between edges → md_busy=0 and all choices 01 immediately. After release, ex_md_start=0 keeps fsm=RUN.
